tage_ghist_ckpt: RTL and testbench

//  Speculative global-history unit for the TAGE front end. Shifts predicted

---
 rtl/tage_ghist_ckpt.sv | 109 ++++++++++
 tb/tb_tage_ghist_ckpt.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tage_ghist_ckpt.sv
// Speculative/architectural global history with per-branch checkpoints and folded output.
// Optional TAGE_GHIST_PERF_EN adds saturating flush and full-stall counters.
module tage_ghist_ckpt #(
  parameter int GHR_LEN    = 64,
  parameter int CKPT_DEPTH = 8,
  parameter int FOLD_W     = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pred_valid,
  input  logic                            pred_taken,
  output logic                            pred_ready,
  output logic [$clog2(CKPT_DEPTH)-1:0]   pred_ckpt_id,
  input  logic                            commit_valid,
  input  logic                            commit_taken,
  input  logic                            flush_valid,
  input  logic [$clog2(CKPT_DEPTH)-1:0]   flush_id,
  input  logic                            flush_taken,
  output logic [GHR_LEN-1:0]              spec_ghr,
  output logic [GHR_LEN-1:0]              arch_ghr,
  output logic [FOLD_W-1:0]               fold_hist,
  output logic [$clog2(CKPT_DEPTH):0]     ckpt_count
`ifdef TAGE_GHIST_PERF_EN
  ,
  output logic [31:0]                     flush_cnt,
  output logic [31:0]                     full_stall_cnt
`endif
);

  localparam int PTR_W  = $clog2(CKPT_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int NCHUNK = (GHR_LEN + FOLD_W - 1) / FOLD_W;

  logic [GHR_LEN-1:0] ckpt [CKPT_DEPTH];
  logic [PTR_W-1:0]   head, tail, head_next, tail_next;
  logic [CNT_W-1:0]   count_next;
  logic [GHR_LEN-1:0] spec_next;
  logic [PTR_W-1:0]   flush_off;
  logic               flush_ok, pred_fire, commit_fire;
  logic [NCHUNK*FOLD_W-1:0] padded;

  assign pred_ready   = (ckpt_count != CNT_W'(CKPT_DEPTH));
  assign pred_ckpt_id = tail;

  // An id is live when its distance from head is below the live count.
  assign flush_off   = flush_id - head;
  assign flush_ok    = flush_valid && ({1'b0, flush_off} < ckpt_count);
  assign pred_fire   = pred_valid && pred_ready && !flush_ok;
  assign commit_fire = commit_valid && (ckpt_count != '0);

  always_comb begin
    head_next  = head + PTR_W'(commit_fire);
    tail_next  = tail;
    spec_next  = spec_ghr;
    count_next = ckpt_count;
    if (flush_ok) begin
      tail_next  = flush_id + PTR_W'(1);
      spec_next  = {ckpt[flush_id][GHR_LEN-2:0], flush_taken};
      count_next = {1'b0, flush_off} + CNT_W'(1);
    end else if (pred_fire) begin
      tail_next  = tail + PTR_W'(1);
      spec_next  = {spec_ghr[GHR_LEN-2:0], pred_taken};
      count_next = ckpt_count + CNT_W'(1);
    end
    if (commit_fire) count_next = count_next - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      ckpt_count <= '0;
      spec_ghr   <= '0;
      arch_ghr   <= '0;
    end else begin
      head       <= head_next;
      tail       <= tail_next;
      ckpt_count <= count_next;
      spec_ghr   <= spec_next;
      if (commit_fire) arch_ghr <= {arch_ghr[GHR_LEN-2:0], commit_taken};
    end
  end

  // Checkpoint storage needs no reset; only live slots are ever read.
  always_ff @(posedge clk) begin
    if (pred_fire) ckpt[tail] <= spec_ghr;
  end

  always_comb begin
    padded = '0;
    padded[GHR_LEN-1:0] = spec_ghr;
    fold_hist = '0;
    for (int c = 0; c < NCHUNK; c++) fold_hist ^= padded[c*FOLD_W +: FOLD_W];
  end

`ifdef TAGE_GHIST_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt      <= '0;
      full_stall_cnt <= '0;
    end else begin
      if (flush_ok && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
      if (pred_valid && !pred_ready && full_stall_cnt != '1)
        full_stall_cnt <= full_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tage_ghist_ckpt.sv
// Randomized and directed check of tage_ghist_ckpt against a queue-based history model.
module tb_tage_ghist_ckpt;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pred_valid = 0, pred_taken = 0, commit_valid = 0, commit_taken = 0;
  logic       flush_valid = 0, flush_taken = 0;
  logic [1:0] flush_id = '0;
  logic       pred_ready;
  logic [1:0] pred_ckpt_id;
  logic [7:0] spec_ghr, arch_ghr;
  logic [2:0] fold_hist;
  logic [2:0] ckpt_count;
`ifdef TAGE_GHIST_PERF_EN
  logic [31:0] flush_cnt, full_stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_spec, m_arch;
  logic [7:0] m_q[$];
  int         m_head;
  int         m_flush_cnt, m_stall_cnt;

  always #5 clk = ~clk;

  tage_ghist_ckpt #(.GHR_LEN(8), .CKPT_DEPTH(4), .FOLD_W(3)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_ready(pred_ready), .pred_ckpt_id(pred_ckpt_id),
    .commit_valid(commit_valid), .commit_taken(commit_taken),
    .flush_valid(flush_valid), .flush_id(flush_id), .flush_taken(flush_taken),
    .spec_ghr(spec_ghr), .arch_ghr(arch_ghr), .fold_hist(fold_hist),
    .ckpt_count(ckpt_count)
`ifdef TAGE_GHIST_PERF_EN
    , .flush_cnt(flush_cnt), .full_stall_cnt(full_stall_cnt)
`endif
  );

  function automatic logic [2:0] foldRef(input logic [7:0] s);
    logic [2:0] r = '0;
    for (int i = 0; i < 8; i++) r[i % 3] ^= s[i];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_spec = '0; m_arch = '0; m_q.delete(); m_head = 0;
    m_flush_cnt = 0; m_stall_cnt = 0;
  endtask

  task automatic checkAll();
    checkOutput("pred_ready", pred_ready, m_q.size() < 4);
    checkOutput("pred_ckpt_id", pred_ckpt_id, (m_head + m_q.size()) % 4);
    checkOutput("spec_ghr", spec_ghr, m_spec);
    checkOutput("arch_ghr", arch_ghr, m_arch);
    checkOutput("fold_hist", fold_hist, foldRef(m_spec));
    checkOutput("ckpt_count", ckpt_count, m_q.size());
`ifdef TAGE_GHIST_PERF_EN
    checkOutput("flush_cnt", flush_cnt, m_flush_cnt);
    checkOutput("full_stall_cnt", full_stall_cnt, m_stall_cnt);
`endif
  endtask

  // Model of one clock edge: live branches are a queue of pre-shift histories, oldest first.
  task automatic modelStep();
    bit         ready   = m_q.size() < 4;
    bit         cmt_ok  = commit_valid && m_q.size() != 0;
    int         off     = (int'(flush_id) - m_head + 4) % 4;
    bit         fl_ok   = flush_valid && off < m_q.size();
    logic [7:0] snap;
    if (pred_valid && !ready) m_stall_cnt++;
    if (fl_ok) begin
      snap = m_q[off];
      m_spec = {snap[6:0], flush_taken};
      while (m_q.size() > off + 1) void'(m_q.pop_back());
      m_flush_cnt++;
    end else if (pred_valid && ready) begin
      m_q.push_back(m_spec);
      m_spec = {m_spec[6:0], pred_taken};
    end
    if (cmt_ok) begin
      void'(m_q.pop_front());
      m_head = (m_head + 1) % 4;
      m_arch = {m_arch[6:0], commit_taken};
    end
  endtask

  task automatic applyStimulus(input bit pv, input bit pt, input bit cv, input bit ct,
                               input bit fv, input logic [1:0] fid, input bit ft);
    @(negedge clk);
    pred_valid = pv; pred_taken = pt; commit_valid = cv; commit_taken = ct;
    flush_valid = fv; flush_id = fid; flush_taken = ft;
    checkAll();
    @(posedge clk);
    modelStep();
  endtask

  task automatic settle();
    @(negedge clk);
    pred_valid = 0; commit_valid = 0; flush_valid = 0;
    checkAll();
  endtask

  // Reset asserted between edges so the asynchronous path is what clears the outputs.
  task automatic asyncReset();
    @(negedge clk);
    pred_valid = 0; commit_valid = 0; flush_valid = 0;
    #2 rst = 1'b1;
    #1 modelReset();
    checkAll();
    checkOutput("rst_spec_zero", spec_ghr, 8'h00);
    checkOutput("rst_count_zero", ckpt_count, 3'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    modelReset();
    #12 rst = 1'b0;

    // Predict T,T,N
    settle();
    checkOutput("reset_ready", pred_ready, 1'b1);
    applyStimulus(1, 1, 0, 0, 0, 2'd0, 0);
    applyStimulus(1, 1, 0, 0, 0, 2'd0, 0);
    applyStimulus(1, 0, 0, 0, 0, 2'd0, 0);
    settle();
    checkOutput("ttn_spec", spec_ghr, 8'b0000_0110);
    checkOutput("ttn_count", ckpt_count, 3'd3);

    // Fill, drop 5th predict while committing
    asyncReset();
    repeat (4) applyStimulus(1, 1, 0, 0, 0, 2'd0, 0);
    settle();
    checkOutput("full_ready", pred_ready, 1'b0);
    applyStimulus(1, 0, 1, 1, 0, 2'd0, 0);
    settle();
    checkOutput("full_drop_spec", spec_ghr, 8'h0F);
    checkOutput("after_commit_ready", pred_ready, 1'b1);
    checkOutput("after_commit_arch", arch_ghr, 8'h01);

    // Flush id1 not-taken, then flush+predict, then non-live flush
    asyncReset();
    repeat (4) applyStimulus(1, 1, 0, 0, 0, 2'd0, 0);
    applyStimulus(0, 0, 0, 0, 1, 2'd1, 0);
    settle();
    checkOutput("flush_spec", spec_ghr, 8'b0000_0010);
    checkOutput("flush_count", ckpt_count, 3'd2);
    checkOutput("flush_next_id", pred_ckpt_id, 2'd2);
    applyStimulus(1, 1, 0, 0, 1, 2'd0, 1);
    applyStimulus(1, 0, 0, 0, 1, 2'd3, 0);
    applyStimulus(0, 0, 0, 0, 1, 2'd3, 1);
    settle();
    checkOutput("flush_pred_tail", pred_ckpt_id, 2'd2);

    // Back-to-back predict/commit across wrap, then drain
    asyncReset();
    applyStimulus(1, 1, 0, 0, 0, 2'd0, 0);
    for (int i = 1; i < 10; i++) applyStimulus(1, i[0], 1, 1'b1, 0, 2'd0, 0);
    applyStimulus(0, 0, 1, 0, 0, 2'd0, 0);
    settle();
    checkOutput("drain_count", ckpt_count, 3'd0);
    checkOutput("drain_id", pred_ckpt_id, 2'd2);

    // Build spec 1011_0110 and check the fold
    asyncReset();
    applyStimulus(1, 1, 0, 0, 0, 2'd0, 0);
    applyStimulus(1, 0, 1, 1, 0, 2'd0, 0);
    applyStimulus(1, 1, 1, 0, 0, 2'd0, 0);
    applyStimulus(1, 1, 1, 1, 0, 2'd0, 0);
    applyStimulus(1, 0, 1, 1, 0, 2'd0, 0);
    applyStimulus(1, 1, 1, 0, 0, 2'd0, 0);
    applyStimulus(1, 1, 1, 1, 0, 2'd0, 0);
    applyStimulus(1, 0, 1, 1, 0, 2'd0, 0);
    settle();
    checkOutput("fold_spec", spec_ghr, 8'b1011_0110);
    checkOutput("fold_hist_b6", fold_hist, 3'b010);

    // Random traffic with occasional mid-flight resets
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) asyncReset();
      applyStimulus($urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 99) < 40, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 99) < 15, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 1) == 1);
    end
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
